// File: rtl/fpu_types_pkg.sv
// Shared types for the FPU decode queue: opcode enum, select codes,
// raw instruction field layout and the decoded control word.
package fpu_types_pkg;

  typedef enum logic [6:0] {
    OPC_OPFP   = 7'b1010011,
    OPC_FMADD  = 7'b1000011,
    OPC_FMSUB  = 7'b1000111,
    OPC_FNMSUB = 7'b1001011,
    OPC_FNMADD = 7'b1001111
  } fpu_opcode_e;

  localparam logic [2:0] SEL_OPFP   = 3'd0;
  localparam logic [2:0] SEL_FMADD  = 3'd1;
  localparam logic [2:0] SEL_FMSUB  = 3'd2;
  localparam logic [2:0] SEL_FNMADD = 3'd3;
  localparam logic [2:0] SEL_FNMSUB = 3'd4;
  localparam logic [2:0] SEL_ILL    = 3'd7;

  typedef struct packed {
    logic [4:0] funct5;
    logic [1:0] fmt;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] rm;
    logic [4:0] rd;
    logic [6:0] opcode;
  } fpu_insn_t;

  typedef struct packed {
    logic [2:0] select;
    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [2:0] rm;
    logic [1:0] fmt;
    logic       illegal;
  } fpu_decode_t;

endpackage

// File: rtl/fpu_insn_decode.sv
// Combinational RV32 FP instruction decode into fpu_decode_t.
// FPU_DECODE_FMA_EN enables the R4 (fused multiply-add) opcodes.
module fpu_insn_decode
  import fpu_types_pkg::*;
#(
  parameter logic [3:0] FMT_MASK = 4'b0101
) (
  input  logic [31:0]  insn,
  output fpu_decode_t  dec
);

  fpu_insn_t f;
  assign f = fpu_insn_t'(insn);

  always_comb begin
    dec        = '0;
    dec.rd     = f.rd;
    dec.rs1    = f.rs1;
    dec.rs2    = f.rs2;
    dec.rm     = f.rm;
    dec.fmt    = f.fmt;
    dec.select = SEL_ILL;
    case (f.opcode)
      OPC_OPFP:   begin dec.select = SEL_OPFP;   dec.op  = f.funct5; end
`ifdef FPU_DECODE_FMA_EN
      OPC_FMADD:  begin dec.select = SEL_FMADD;  dec.rs3 = f.funct5; end
      OPC_FMSUB:  begin dec.select = SEL_FMSUB;  dec.rs3 = f.funct5; end
      OPC_FNMADD: begin dec.select = SEL_FNMADD; dec.rs3 = f.funct5; end
      OPC_FNMSUB: begin dec.select = SEL_FNMSUB; dec.rs3 = f.funct5; end
`endif
      default:    dec.select = SEL_ILL;
    endcase
    // rm 111 is dynamic rounding and stays legal
    dec.illegal = (dec.select == SEL_ILL) || !FMT_MASK[f.fmt] ||
                  (f.rm == 3'b101) || (f.rm == 3'b110);
  end

endmodule

// File: rtl/fpu_decode_queue.sv
// Decode-at-enqueue FIFO of FP instructions; stores decoded control words.
// FPU_DECODE_FMA_EN (in fpu_insn_decode) enables R4 opcode decode.
module fpu_decode_queue
  import fpu_types_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [3:0] FMT_MASK = 4'b0101,
  localparam int        CW       = $clog2(DEPTH+1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   insn,
  output logic          out_valid,
  input  logic          out_ready,
  output fpu_decode_t   out_ctrl,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fpu_decode_t   mem [DEPTH];
  fpu_decode_t   dec;
  logic [AW-1:0] wptr, rptr;
  logic          enq, deq;

  fpu_insn_decode #(.FMT_MASK(FMT_MASK)) u_dec (
    .insn (insn),
    .dec  (dec)
  );

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign out_ctrl  = out_valid ? mem[rptr] : '0;

  // Power-of-two DEPTH lets the pointers wrap by natural overflow
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem[wptr] <= dec;
        wptr      <= wptr + 1'b1;
      end
      if (deq) rptr <= rptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_decode_queue.sv
// Scoreboard bench for fpu_decode_queue (DEPTH 4, FMT_MASK 4'b0101).
module tb_fpu_decode_queue;
  import fpu_types_pkg::*;

  localparam logic [3:0] MASK = 4'b0101;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] insn = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  fpu_decode_t out_ctrl;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;
  fpu_decode_t sb [$];
  logic [6:0]  opc [6] = '{7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h13};

  fpu_decode_queue #(.DEPTH(4), .FMT_MASK(MASK)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .insn(insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic fpu_decode_t model(input logic [31:0] i);
    fpu_decode_t d;
    d        = '0;
    d.rd     = i[11:7];
    d.rm     = i[14:12];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.fmt    = i[26:25];
    d.select = 3'd7;
    if (i[6:0] == 7'h53) begin
      d.select = 3'd0;
      d.op     = i[31:27];
    end
`ifdef FPU_DECODE_FMA_EN
    else if (i[6:0] == 7'h43) d.select = 3'd1;
    else if (i[6:0] == 7'h47) d.select = 3'd2;
    else if (i[6:0] == 7'h4F) d.select = 3'd3;
    else if (i[6:0] == 7'h4B) d.select = 3'd4;
    if (d.select >= 3'd1 && d.select <= 3'd4) d.rs3 = i[31:27];
`endif
    d.illegal = (d.select == 3'd7) || (MASK[d.fmt] == 1'b0) ||
                (d.rm == 3'd5) || (d.rm == 3'd6);
    return d;
  endfunction

  function automatic logic [31:0] rnd_insn();
    logic [31:0] r;
    r      = $urandom;
    r[6:0] = opc[$urandom_range(0, 5)];
    return r;
  endfunction

  // Outputs checked mid-cycle, then the transfers of this cycle applied to the model
  always @(negedge CLK) begin
    if (nRST) begin
      chk("count", 64'(count), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 4));
      if (!out_valid) chk("idle_ctrl", 64'(out_ctrl), 64'd0);
      if (flush) sb.delete();
      else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("deq_empty", 64'd1, 64'd0);
          else chk("head", 64'(out_ctrl), 64'(sb.pop_front()));
        end
        if (in_valid && in_ready) sb.push_back(model(insn));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push1(input logic [31:0] v);
    in_valid = 1'b1;
    insn     = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 12) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_done", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ctrl", 64'(out_ctrl), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    step();

    // FADD.S visible one edge after enqueue
    push1(32'h002081D3);
    chk("fadd_valid", 64'(out_valid), 64'd1);
    chk("fadd_sel", 64'(out_ctrl.select), 64'd0);
    chk("fadd_op", 64'(out_ctrl.op), 64'd0);
    chk("fadd_rd", 64'(out_ctrl.rd), 64'd3);
    chk("fadd_rs1", 64'(out_ctrl.rs1), 64'd1);
    chk("fadd_rs2", 64'(out_ctrl.rs2), 64'd2);
    chk("fadd_fmt", 64'(out_ctrl.fmt), 64'd0);
    chk("fadd_ill", 64'(out_ctrl.illegal), 64'd0);
    drain();

    push1(32'h242081C3);
`ifdef FPU_DECODE_FMA_EN
    chk("fmadd_sel", 64'(out_ctrl.select), 64'd1);
    chk("fmadd_rs3", 64'(out_ctrl.rs3), 64'd4);
    chk("fmadd_ill", 64'(out_ctrl.illegal), 64'd0);
`else
    chk("fmadd_sel", 64'(out_ctrl.select), 64'd7);
    chk("fmadd_rs3", 64'(out_ctrl.rs3), 64'd0);
    chk("fmadd_ill", 64'(out_ctrl.illegal), 64'd1);
`endif
    chk("fmadd_fmt", 64'(out_ctrl.fmt), 64'd2);
    drain();

    push1(32'h022081D3);
    chk("faddd_sel", 64'(out_ctrl.select), 64'd0);
    chk("faddd_ill", 64'(out_ctrl.illegal), 64'd1);
    drain();
    push1(32'h00000013);
    chk("addi_sel", 64'(out_ctrl.select), 64'd7);
    chk("addi_ill", 64'(out_ctrl.illegal), 64'd1);
    drain();
    push1(32'h0020F1D3);
    chk("rm_dyn_ill", 64'(out_ctrl.illegal), 64'd0);
    drain();
    push1(32'h0020D1D3);
    chk("rm101_ill", 64'(out_ctrl.illegal), 64'd1);
    drain();

    // Fill to full, hold a 5th, then stream across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      insn = rnd_insn();
      step();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    insn = rnd_insn();
    step();
    chk("held_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    step();
    chk("after_deq", 64'(count), 64'd3);
    for (int i = 0; i < 8; i++) begin
      insn = rnd_insn();
      step();
      chk("stream_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    drain();

    // Flush wins over same-cycle enqueue and dequeue
    for (int i = 0; i < 3; i++) push1(rnd_insn());
    chk("pre_flush", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; insn = rnd_insn();
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-operation
    push1(rnd_insn());
    push1(rnd_insn());
    chk("pre_rst", 64'(count), 64'd2);
    nRST = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    step();
    nRST = 1'b1;
    step();
    push1(32'h002081D3);
    chk("post_rst_rd", 64'(out_ctrl.rd), 64'd3);
    drain();

    // Random traffic, scoreboard-checked
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      insn      = rnd_insn();
      step();
    end
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
